// File: rtl/inst_word_packer_if.sv
// Bus write-word stream in, packed instruction FIFO write port out.
// The packer takes the slave modport and the producer/FIFO side takes the master modport.
interface inst_word_packer_if #(
  parameter int BUS_DATA_WIDTH = 32
);
  logic [BUS_DATA_WIDTH-1:0]   bus_data;
  logic                        bus_data_valid;
  logic                        bus_data_ready;
  logic [2*BUS_DATA_WIDTH-1:0] inst_fifo_wr_data;
  logic                        inst_fifo_wr_en;
  logic                        inst_fifo_full;

  modport slave (
    input  bus_data, bus_data_valid, inst_fifo_full,
    output bus_data_ready, inst_fifo_wr_data, inst_fifo_wr_en
  );

  modport master (
    output bus_data, bus_data_valid, inst_fifo_full,
    input  bus_data_ready, inst_fifo_wr_data, inst_fifo_wr_en
  );
endinterface

// File: rtl/inst_word_packer.sv
// Packs pairs of 32-bit bus words into 64-bit instructions for the sequencer FIFO.
// Optional instruction validation is enabled with `define INST_PACKER_VALIDATE_EN.
module inst_word_packer #(
  parameter int BUS_DATA_WIDTH = 32,
  parameter int COUNTER_WIDTH  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  inst_word_packer_if.slave        bus,
  output logic                     half_pending,
  output logic [COUNTER_WIDTH-1:0] word_count,
  output logic [COUNTER_WIDTH-1:0] inst_count,
  output logic [COUNTER_WIDTH-1:0] reject_count,
  output logic                     inst_error
);
  localparam int IW = 2 * BUS_DATA_WIDTH;
  localparam logic [0:0] LO = 1'b0;
  localparam logic [0:0] HI = 1'b1;

  logic [0:0]                phase;
  logic [BUS_DATA_WIDTH-1:0] lo_reg;
  logic [IW-1:0]             out_reg;
  logic                      out_valid;

  logic          out_slot_free;
  logic          wr_en;
  logic          ready;
  logic          xfer;
  logic          reject;
  logic          load;
  logic [IW-1:0] inst;

  assign inst          = {bus.bus_data, lo_reg};
  assign wr_en         = out_valid & ~bus.inst_fifo_full;
  assign out_slot_free = ~out_valid | ~bus.inst_fifo_full;
  // A low word only needs lo_reg, so it never waits on the FIFO.
  assign ready         = ~flush & ((phase == LO) | out_slot_free);
  assign xfer          = bus.bus_data_valid & ready;
  assign load          = xfer & (phase == HI) & ~reject;

  assign bus.bus_data_ready    = ready;
  assign bus.inst_fifo_wr_en   = wr_en;
  assign bus.inst_fifo_wr_data = out_reg;
  assign half_pending          = (phase == HI);

  always_ff @(posedge clock) begin
    if (reset) begin
      phase      <= LO;
      lo_reg     <= '0;
      out_reg    <= '0;
      out_valid  <= 1'b0;
      word_count <= '0;
      inst_count <= '0;
    end else begin
      if (xfer)  word_count <= word_count + COUNTER_WIDTH'(1);
      if (wr_en) inst_count <= inst_count + COUNTER_WIDTH'(1);
      if (flush) begin
        phase     <= LO;
        out_valid <= 1'b0;
        lo_reg    <= '0;
      end else begin
        if (xfer) begin
          phase <= (phase == LO) ? HI : LO;
          if (phase == LO) lo_reg <= bus.bus_data;
        end
        // A load in the same cycle as a drain keeps out_valid set with new data.
        if (load) begin
          out_reg   <= inst;
          out_valid <= 1'b1;
        end else if (wr_en) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

`ifdef INST_PACKER_VALIDATE_EN
  logic [3:0]  opcode;
  logic [23:0] duration;

  assign opcode   = inst[63:60];
  assign duration = inst[55:32];
  assign reject   = (opcode > 4'd6) ||
                    (((opcode == 4'd0) || (opcode == 4'd2)) && (duration < 24'd6));

  always_ff @(posedge clock) begin
    if (reset) begin
      reject_count <= '0;
      inst_error   <= 1'b0;
    end else if (xfer && (phase == HI) && reject) begin
      reject_count <= reject_count + COUNTER_WIDTH'(1);
      inst_error   <= 1'b1;
    end
  end
`else
  assign reject       = 1'b0;
  assign reject_count = '0;
  assign inst_error   = 1'b0;
`endif
endmodule

// File: tb/tb_inst_word_packer.sv
// Scoreboard bench for inst_word_packer: stimulus pushes expected instructions,
// a negedge monitor pops and compares each FIFO write.
module tb_inst_word_packer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        half_pending;
  logic [31:0] word_count, inst_count, reject_count;
  logic        inst_error;

  inst_word_packer_if #(.BUS_DATA_WIDTH(32)) bus_if ();

  inst_word_packer #(.BUS_DATA_WIDTH(32), .COUNTER_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .flush(flush), .bus(bus_if.slave),
    .half_pending(half_pending), .word_count(word_count), .inst_count(inst_count),
    .reject_count(reject_count), .inst_error(inst_error)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [63:0] sb[$];
  int          wr_cyc[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  // Monitor: every FIFO write must match the oldest expected instruction.
  always @(negedge clock) begin
    if (bus_if.inst_fifo_wr_en === 1'b1) begin
      wr_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got 0x%0h want no write", bus_if.inst_fifo_wr_data);
      end else begin
        chk("wr_data", bus_if.inst_fifo_wr_data, sb.pop_front());
      end
    end
  end

  task automatic sync();
    @(posedge clock); #1;
  endtask

  // Holds valid with d until a transfer edge; returns 1 time unit after that edge.
  task automatic send_word(input logic [31:0] d);
    int   t = 0;
    logic r;
    bus_if.bus_data       = d;
    bus_if.bus_data_valid = 1'b1;
    do begin
      @(negedge clock);
      r = bus_if.bus_data_ready;
      @(posedge clock); #1;
      t++;
    end while (!r && t < 50);
    if (!r) begin
      n_checks++;
      $display("FAIL send_timeout: got ready=0 want 1");
    end
  endtask

  task automatic idle();
    bus_if.bus_data_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] inst_a, inst_b;
    int          base;
    bus_if.bus_data       = '0;
    bus_if.bus_data_valid = 1'b0;
    bus_if.inst_fifo_full = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clock);
    chk("rst_wr_en",   bus_if.inst_fifo_wr_en, 0);
    chk("rst_wr_data", bus_if.inst_fifo_wr_data, 0);
    chk("rst_ready",   bus_if.bus_data_ready, 1);
    chk("rst_half",    half_pending, 0);
    chk("rst_words",   word_count, 0);
    chk("rst_insts",   inst_count, 0);
    chk("rst_rejects", reject_count, 0);
    chk("rst_error",   inst_error, 0);
    sync();

    // T1 pack
    sb.push_back(64'h0000000A_000000FF);
    send_word(32'h0000_00FF);
    send_word(32'h0000_000A);
    idle(); sync(); sync();
    @(negedge clock);
    chk("t1_insts", inst_count, 1);
    chk("t1_words", word_count, 2);
    sync();

    // T2 stall: A held in out_reg, B low word accepted, B high word must wait
    bus_if.inst_fifo_full = 1'b1;
    inst_a = 64'h1000_0020_0000_0011;
    inst_b = 64'h1000_0030_0000_0022;
    sb.push_back(inst_a);
    send_word(inst_a[31:0]);
    send_word(inst_a[63:32]);
    send_word(inst_b[31:0]);
    sb.push_back(inst_b);
    bus_if.bus_data = inst_b[63:32];
    repeat (3) begin
      @(negedge clock);
      chk("t2_ready_low", bus_if.bus_data_ready, 0);
      chk("t2_wr_en_low", bus_if.inst_fifo_wr_en, 0);
      chk("t2_held",      bus_if.inst_fifo_wr_data, inst_a);
    end
    sync();
    bus_if.inst_fifo_full = 1'b0;
    @(negedge clock);
    chk("t2_ready_rel", bus_if.bus_data_ready, 1);
    sync();
    idle(); sync(); sync();
    chk("t2_no_gap", 64'(wr_cyc[$] - wr_cyc[$-1]), 1);
    @(negedge clock);
    chk("t2_insts", inst_count, 3);
    sync();

    // T3 flush drops the pending low word
    send_word(32'h0000_1234);
    idle();
    @(negedge clock);
    chk("t3_half_before", half_pending, 1);
    sync();
    flush = 1'b1;
    @(negedge clock);
    chk("t3_ready_flush", bus_if.bus_data_ready, 0);
    sync();
    flush = 1'b0;
    @(negedge clock);
    chk("t3_half_after", half_pending, 0);
    chk("t3_words_kept", word_count, 7);
    sync();
    sb.push_back(64'h20000006_000000AA);
    send_word(32'h0000_00AA);
    send_word(32'h2000_0006);
    idle(); sync(); sync();
    @(negedge clock);
    chk("t3_words", word_count, 9);
    chk("t3_insts", inst_count, 4);
    sync();

    // T4 streaming 100 instructions
    for (int i = 0; i < 100; i++) begin
      sb.push_back({32'h1000_0000 | 32'(i), 32'(i + 1000)});
      send_word(32'(i + 1000));
      send_word(32'h1000_0000 | 32'(i));
    end
    idle(); repeat (3) sync();
    chk("t4_cadence", 64'(wr_cyc[$] - wr_cyc[$-99]), 198);
    @(negedge clock);
    chk("t4_insts", 64'(inst_count - 32'd4), 100);
    chk("t4_words", word_count, 209);
    sync();

    // T5 validation: opcode 7, then opcode 0 with duration 3, then a good one
`ifndef INST_PACKER_VALIDATE_EN
    sb.push_back(64'h70000000_00000011);
    sb.push_back(64'h00000003_00000022);
`endif
    send_word(32'h0000_0011);
    send_word(32'h7000_0000);
    send_word(32'h0000_0022);
    send_word(32'h0000_0003);
    sb.push_back(64'h10000005_00000033);
    send_word(32'h0000_0033);
    send_word(32'h1000_0005);
    idle(); repeat (3) sync();
    @(negedge clock);
    chk("t5_words", word_count, 215);
`ifdef INST_PACKER_VALIDATE_EN
    chk("t5_rejects", reject_count, 2);
    chk("t5_error",   inst_error, 1);
    chk("t5_insts",   inst_count, 105);
`else
    chk("t5_rejects", reject_count, 0);
    chk("t5_error",   inst_error, 0);
    chk("t5_insts",   inst_count, 107);
`endif
    sync();

    // T6 reset with a held instruction and a pending low word
    bus_if.inst_fifo_full = 1'b1;
    send_word(32'h0000_0044);
    send_word(32'h1000_0001);
    send_word(32'h0000_0055);
    idle();
    @(negedge clock);
    chk("t6_half_before", half_pending, 1);
    sync();
    reset = 1'b1;
    sync();
    reset = 1'b0;
    @(negedge clock);
    chk("t6_wr_en",    bus_if.inst_fifo_wr_en, 0);
    chk("t6_wr_data",  bus_if.inst_fifo_wr_data, 0);
    chk("t6_words",    word_count, 0);
    chk("t6_insts",    inst_count, 0);
    chk("t6_rejects",  reject_count, 0);
    chk("t6_error",    inst_error, 0);
    chk("t6_half",     half_pending, 0);
    sync();
    bus_if.inst_fifo_full = 1'b0;
    @(negedge clock);
    chk("t6_wr_en_released", bus_if.inst_fifo_wr_en, 0);
    sync(); sync();
    chk("sb_empty", 64'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
